// File: rtl/inv_shiftrows_stream_pkg.sv
// Shared AES types and the ShiftRows source-index helper used by every
// ShiftRows/InvShiftRows stage so all of them agree on the k = r + 4c order.
package aes_pkg;
   localparam int AES_NB          = 4;
   localparam int AES_BLOCK_BYTES = 16;

   typedef logic [7:0]   byte_t;
   typedef byte_t [15:0] state_t;

   // Output position k takes the byte from the returned index; columns wrap mod 4.
   function automatic logic [3:0] shiftrows_src(input logic [3:0] k, input logic fwd);
      logic [1:0] r;
      logic [1:0] c;
      r = k[1:0];
      c = k[3:2];
      c = fwd ? (c + r) : (c - r);
      return {c, r};
   endfunction
endpackage

// File: rtl/inv_shiftrows_stream_bank.sv
// One 16-byte state bank: byte write port, combinational read port, full and
// mode flags. The mode flag is taken with byte 0 of each block.
module shiftrows_bank
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [3:0] wr_idx,
   input  byte_t      wr_data,
   input  logic       wr_fwd,
   input  logic       set_full,
   input  logic       clr_full,
   input  logic [3:0] rd_idx,
   output byte_t      rd_data,
   output logic       full,
   output logic       fwd
);
   state_t mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem  <= '0;
         full <= 1'b0;
         fwd  <= 1'b0;
      end else begin
         if (wr_en) mem[wr_idx] <= wr_data;
         if (wr_en && wr_idx == 4'd0) fwd <= wr_fwd;
         if (set_full) full <= 1'b1;
         else if (clr_full) full <= 1'b0;
      end
   end

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/inv_shiftrows_stream.sv
// Byte-serial ping-pong (Inv)ShiftRows: one bank fills while the other drains,
// so 1 byte/cycle is sustained with no bubble between blocks.
module inv_shiftrows_stream
   import aes_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int BLOCK_BYTES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_fwd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              err
);
   localparam logic [3:0] CNT_LAST = 4'(BLOCK_BYTES - 1);

   logic       wr_sel, rd_sel;
   logic [3:0] wr_cnt, rd_cnt;
   logic       err_q;
   logic [1:0] full, fwd, wr_en, set_full, clr_full;
   byte_t      rd_data [2];
   logic       in_xfer, out_xfer, wr_term, rd_term, early_last;
   logic [3:0] rd_idx;

   assign in_ready   = !full[wr_sel];
   assign in_xfer    = in_valid && in_ready;
   assign out_xfer   = out_valid && out_ready;
   assign wr_term    = in_xfer && (wr_cnt == CNT_LAST);
   assign early_last = in_xfer && in_last && (wr_cnt != CNT_LAST);
   assign rd_term    = out_xfer && (rd_cnt == CNT_LAST);
   assign rd_idx     = shiftrows_src(rd_cnt, fwd[rd_sel]);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign wr_en[b]    = in_xfer && (wr_sel == 1'(b));
      assign set_full[b] = wr_term && (wr_sel == 1'(b));
      assign clr_full[b] = rd_term && (rd_sel == 1'(b));

      shiftrows_bank u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[b]),
         .wr_idx   (wr_cnt),
         .wr_data  (in_data),
         .wr_fwd   (in_fwd),
         .set_full (set_full[b]),
         .clr_full (clr_full[b]),
         .rd_idx   (rd_idx),
         .rd_data  (rd_data[b]),
         .full     (full[b]),
         .fwd      (fwd[b])
      );
   end

   assign out_valid = full[rd_sel];
   assign out_data  = rd_data[rd_sel];
   assign out_last  = out_valid && (rd_cnt == CNT_LAST);
   assign err       = err_q;

   // An early in_last drops the partial block; a missing one still completes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         wr_cnt <= '0;
         rd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= in_xfer && (in_last != (wr_cnt == CNT_LAST));
         if (wr_term || early_last) wr_cnt <= '0;
         else if (in_xfer) wr_cnt <= wr_cnt + 4'd1;
         if (wr_term) wr_sel <= !wr_sel;
         if (rd_term) begin
            rd_cnt <= '0;
            rd_sel <= !rd_sel;
         end else if (out_xfer) begin
            rd_cnt <= rd_cnt + 4'd1;
         end
      end
   end
endmodule
